// File: rtl/imem_uart_loader.sv
`timescale 1ns/1ps
// imem_uart_loader
//   Serial boot loader for the core's instruction memory. Receives a framed
//   image over an 8N1 UART line and writes 32-bit words into imem. The core
//   is held in reset until the full image has been written and its XOR
//   checksum has matched.
//
//   Frame: A5, count_lo, count_hi, N*4 data bytes (little-endian words),
//          checksum byte (XOR of all data bytes).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   uart_rx    serial line (idle high), asynchronous to clk
//   load_req   one-cycle pulse; restarts loading from DONE or ERR
//   imem_we    one-cycle imem write strobe
//   imem_addr  word address of the current write
//   imem_wdata word being written
//   cpu_hold   1 = keep the core in reset
//   done       image loaded and verified
//   error      load failed
//   err_code   00 none, 01 framing, 10 count overflow, 11 checksum mismatch
module imem_uart_loader #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state_reg, rx_state_next;
  logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            byte_valid_reg, byte_valid_next;
  logic            frame_err_reg, frame_err_next;
  logic [7:0]      rx_byte;

  assign rx_byte = shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg    <= uart_rx;
      rx_sync_reg    <= rx_meta_reg;
      rx_prev_reg    <= rx_sync_reg;
      rx_state_reg   <= rx_state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          cnt_next      = CW'(HALF - 1);
        end
      end
      RX_START: begin
        if (cnt_reg == '0) begin
          // Line back high at mid start bit: a glitch, not a start bit.
          if (rx_sync_reg) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            cnt_next      = CW'(DIV - 1);
            bit_idx_next  = '0;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          cnt_next   = CW'(DIV - 1);
          if (bit_idx_reg == 3'd7) rx_state_next = RX_STOP;
          else                     bit_idx_next  = bit_idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == '0) begin
          if (rx_sync_reg) byte_valid_next = 1'b1;
          else             frame_err_next  = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------ loader
  typedef enum logic [2:0] {SYNC, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t                state_reg, state_next;
  logic [15:0]           count_reg, count_next;
  logic [ADDR_WIDTH-1:0] word_idx_reg, word_idx_next;
  logic [1:0]            lane_reg, lane_next;
  logic [23:0]           bytes_reg, bytes_next;
  logic [7:0]            acc_reg, acc_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [1:0]            err_code_reg, err_code_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SYNC;
      count_reg    <= '0;
      word_idx_reg <= '0;
      lane_reg     <= '0;
      bytes_reg    <= '0;
      acc_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_idx_reg <= word_idx_next;
      lane_reg     <= lane_next;
      bytes_reg    <= bytes_next;
      acc_reg      <= acc_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    word_idx_next = word_idx_reg;
    lane_next     = lane_reg;
    bytes_next    = bytes_reg;
    acc_next      = acc_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    err_code_next = err_code_reg;
    case (state_reg)
      SYNC: begin
        if (byte_valid_reg && rx_byte == SYNC_BYTE) state_next = CNT_LO;
      end
      CNT_LO: begin
        if (frame_err_reg) begin
          state_next    = ERR;
          err_code_next = 2'b01;
        end else if (byte_valid_reg) begin
          count_next[7:0] = rx_byte;
          state_next      = CNT_HI;
        end
      end
      CNT_HI: begin
        if (frame_err_reg) begin
          state_next    = ERR;
          err_code_next = 2'b01;
        end else if (byte_valid_reg) begin
          count_next    = {rx_byte, count_reg[7:0]};
          acc_next      = '0;  // also cleared for N=0 so the checksum is 00
          word_idx_next = '0;
          lane_next     = '0;
          if ({1'b0, count_next} > MAX_WORDS) begin
            state_next    = ERR;
            err_code_next = 2'b10;
          end else if (count_next == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // The write strobe cycle is spent in DATA; the index advances (or
        // the FSM leaves for CSUM after the last word) once it has issued.
        if (we_reg) begin
          if (16'(word_idx_reg) == count_reg - 16'd1) state_next    = CSUM;
          else                                        word_idx_next = word_idx_reg + 1'b1;
        end else if (frame_err_reg) begin
          state_next    = ERR;
          err_code_next = 2'b01;
        end else if (byte_valid_reg) begin
          acc_next = acc_reg ^ rx_byte;
          if (lane_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = word_idx_reg;
            wdata_next = {rx_byte, bytes_reg};
            lane_next  = 2'd0;
          end else begin
            bytes_next = {rx_byte, bytes_reg[23:8]};
            lane_next  = lane_reg + 2'd1;
          end
        end
      end
      CSUM: begin
        if (frame_err_reg) begin
          state_next    = ERR;
          err_code_next = 2'b01;
        end else if (byte_valid_reg) begin
          if (rx_byte == acc_reg) begin
            state_next = DONE;
          end else begin
            state_next    = ERR;
            err_code_next = 2'b11;
          end
        end
      end
      DONE, ERR: begin
        if (load_req) begin
          state_next    = SYNC;
          err_code_next = 2'b00;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERR);
  assign cpu_hold   = (state_reg != DONE);
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_imem_uart_loader.sv
`timescale 1ns/1ps
module tb_imem_uart_loader;

  localparam int DIV = 10;

  logic        clk, reset, uart_rx, load_req;
  logic        imem_we, cpu_hold, done, error;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;

  imem_uart_loader #(
    .CLK_HZ(1000000), .BAUD(100000), .ADDR_WIDTH(4), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .load_req(load_req),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Write log and byte_valid pulse counter
  int          wr_n = 0;
  int          bv_n = 0;
  logic [3:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr[wr_n & 127] <= imem_addr;
      wr_data[wr_n & 127] <= imem_wdata;
      wr_n <= wr_n + 1;
    end
    if (dut.byte_valid_reg) bv_n <= bv_n + 1;
  end

  typedef struct packed {
    logic [71:0][7:0]  img;
    logic [7:0]        nbytes;
    logic [4:0]        nwr;
    logic [15:0][31:0] wdat;
    logic              exp_done;
    logic              exp_err;
    logic [1:0]        exp_code;
  } vec_t;

  vec_t vecs [0:5];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic put(input int v, input logic [7:0] b);
    vecs[v].img[vecs[v].nbytes] = b;
    vecs[v].nbytes = vecs[v].nbytes + 8'd1;
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_load();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input int v, input string tag);
    int base;
    pulse_load();
    base = wr_n;
    for (int k = 0; k < int'(vecs[v].nbytes); k++) send_byte(vecs[v].img[k], 1'b1);
    repeat (5) @(negedge clk);
    chk($sformatf("%s writes", tag), 32'(wr_n - base), 32'(vecs[v].nwr));
    for (int i = 0; i < int'(vecs[v].nwr); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 32'(wr_addr[(base + i) & 127]), 32'(i));
      chk($sformatf("%s data[%0d]", tag, i), wr_data[(base + i) & 127], vecs[v].wdat[i]);
    end
    chk($sformatf("%s done", tag), 32'(done), 32'(vecs[v].exp_done));
    chk($sformatf("%s error", tag), 32'(error), 32'(vecs[v].exp_err));
    chk($sformatf("%s err_code", tag), 32'(err_code), 32'(vecs[v].exp_code));
    chk($sformatf("%s cpu_hold", tag), 32'(cpu_hold), 32'(!vecs[v].exp_done));
    $display("vec %s: %0d bytes sent, %0d writes seen, done=%0b error=%0b code=%0d",
             tag, vecs[v].nbytes, wr_n - base, done, error, err_code);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          base;
    int          bv0;

    // ---- vector table
    for (int v = 0; v < 6; v++) vecs[v] = '0;
    // 0: two words, checksum 13^93^10 = 90
    put(0, 8'hA5); put(0, 8'h02); put(0, 8'h00);
    put(0, 8'h13); put(0, 8'h00); put(0, 8'h00); put(0, 8'h00);
    put(0, 8'h93); put(0, 8'h00); put(0, 8'h10); put(0, 8'h00);
    put(0, 8'h90);
    vecs[0].nwr = 2; vecs[0].wdat[0] = 32'h00000013; vecs[0].wdat[1] = 32'h00100093;
    vecs[0].exp_done = 1'b1;
    // 1: leading junk ignored, one word, checksum EF^BE^AD^DE = 22
    put(1, 8'h3C); put(1, 8'h00); put(1, 8'hA5); put(1, 8'h01); put(1, 8'h00);
    put(1, 8'hEF); put(1, 8'hBE); put(1, 8'hAD); put(1, 8'hDE); put(1, 8'h22);
    vecs[1].nwr = 1; vecs[1].wdat[0] = 32'hDEADBEEF; vecs[1].exp_done = 1'b1;
    // 2: vector 0 with a wrong checksum
    vecs[2] = vecs[0];
    vecs[2].img[11] = 8'h8D;
    vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1; vecs[2].exp_code = 2'b11;
    // 3: N = 17 exceeds 16-word memory
    put(3, 8'hA5); put(3, 8'h11); put(3, 8'h00);
    vecs[3].exp_err = 1'b1; vecs[3].exp_code = 2'b10;
    // 4: N = 0, checksum 00
    put(4, 8'hA5); put(4, 8'h00); put(4, 8'h00); put(4, 8'h00);
    vecs[4].exp_done = 1'b1;
    // 5: maximum image, N = 16
    put(5, 8'hA5); put(5, 8'h10); put(5, 8'h00);
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = {8'(i), 8'h5A ^ 8'(i), 8'h30 + 8'(i), ~8'(i)};
      vecs[5].wdat[i] = w;
      for (int k = 0; k < 4; k++) begin
        put(5, w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
    put(5, cs);
    vecs[5].nwr = 16; vecs[5].exp_done = 1'b1;

    // ---- reset state
    reset = 1'b1; uart_rx = 1'b1; load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst imem_we", 32'(imem_we), 32'd0);
    chk("rst imem_addr", 32'(imem_addr), 32'd0);
    chk("rst imem_wdata", imem_wdata, 32'd0);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ---- table
    for (int v = 0; v < 6; v++) run_vec(v, $sformatf("v%0d", v));

    // ---- bad checksum, recover with load_req, resend good image
    run_vec(2, "retry_bad");
    pulse_load();
    chk("reload error", 32'(error), 32'd0);
    chk("reload err_code", 32'(err_code), 32'd0);
    chk("reload cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reload done", 32'(done), 32'd0);
    run_vec(0, "retry_good");

    // ---- framing error inside DATA
    pulse_load();
    base = wr_n;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b0);
    repeat (5) @(negedge clk);
    chk("frame error", 32'(error), 32'd1);
    chk("frame err_code", 32'(err_code), 32'd1);
    chk("frame writes", 32'(wr_n - base), 32'd0);
    chk("frame cpu_hold", 32'(cpu_hold), 32'd1);
    $display("frame-error sequence: error=%0b code=%0d", error, err_code);

    // ---- 3-clock glitch in SYNC
    pulse_load();
    bv0 = bv_n;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch bytes", 32'(bv_n - bv0), 32'd0);
    chk("glitch error", 32'(error), 32'd0);
    chk("glitch done", 32'(done), 32'd0);
    $display("glitch sequence: %0d bytes accepted", bv_n - bv0);
    run_vec(1, "post_glitch");

    // ---- reset in the middle of a data byte
    pulse_load();
    base = wr_n;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    fork
      send_byte(8'hEF, 1'b1);
      begin
        repeat (45) @(posedge clk);
        #100 reset = 1'b1;
        #1;
        chk("midrst imem_we", 32'(imem_we), 32'd0);
        chk("midrst imem_addr", 32'(imem_addr), 32'd0);
        chk("midrst imem_wdata", imem_wdata, 32'd0);
        chk("midrst cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst error", 32'(error), 32'd0);
        chk("midrst err_code", 32'(err_code), 32'd0);
      end
    join
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst writes", 32'(wr_n - base), 32'd0);
    $display("mid-frame reset sequence: %0d writes after reset", wr_n - base);
    run_vec(1, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
